spmv_pe_mem_port: RTL and testbench

//  Synthesizable memory responder for one spmv_pe. Accepts the PE's req_mem_* load/store stream, forwards it to the

---
 rtl/spmv_pe_mem_port_pkg.sv | 34 +++
 rtl/spmv_pe_mem_port_rsp_fifo.sv | 54 +++++
 rtl/spmv_pe_mem_port.sv | 168 ++++++++++++++++
 tb/tb_spmv_pe_mem_port.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pe_mem_port_pkg.sv
// Shared definitions for the spmv_pe memory port: bus widths, MC rdctl layout,
// request-queue entry layout and the load rdctl builder.
package spmv_pe_mem_port_pkg;

  localparam int ADDR_W        = 48;
  localparam int DATA_W        = 64;
  localparam int RDCTL_W       = 32;
  localparam int MEM_TAG_W     = 3;
  localparam int RDCTL_TAG_LSB = 0;

  typedef struct packed {
    logic              ld;
    logic              st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
  } req_ent_t;

  localparam int ENT_D_LSB    = 0;
  localparam int ENT_ADDR_LSB = DATA_W;
  localparam int ENT_ST_BIT   = DATA_W + ADDR_W;
  localparam int ENT_LD_BIT   = DATA_W + ADDR_W + 1;

  // Loads carry only the tag to the MC; upper rdctl bits are forced to zero.
  function automatic logic [DATA_W-1:0] ld_rdctl(input logic [DATA_W-1:0] d_or_tag,
                                                 input int tag_w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < tag_w) r[i] = d_or_tag[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spmv_pe_mem_port_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; the caller guarantees it never
// writes when full or reads when empty.
module spmv_rsp_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 67
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en)      cnt_d = cnt_q + CNT_ONE;
    else if (!wr_en && rd_en) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data only; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/spmv_pe_mem_port.sv
// spmv_pe memory port: 2-entry request queue to the MC, credit-bounded load responses.
// Optional define SPMV_MEM_ADDR_CHECK_EN flags misaligned request addresses in err.
module spmv_pe_mem_port
  import spmv_pe_mem_port_pkg::*;
#(
  parameter int RSP_DEPTH = 16,
  parameter int TAG_W     = MEM_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_mem_ld,
  input  logic               req_mem_st,
  input  logic [ADDR_W-1:0]  req_mem_addr,
  input  logic [DATA_W-1:0]  req_mem_d_or_tag,
  output logic               req_mem_stall,
  output logic               rsp_mem_push,
  output logic [TAG_W-1:0]   rsp_mem_tag,
  output logic [DATA_W-1:0]  rsp_mem_q,
  input  logic               rsp_mem_stall,
  output logic               mc_req_ld,
  output logic               mc_req_st,
  output logic [ADDR_W-1:0]  mc_req_vadr,
  output logic [DATA_W-1:0]  mc_req_wrd_rdctl,
  input  logic               mc_req_stall,
  input  logic               mc_rsp_push,
  input  logic [RDCTL_W-1:0] mc_rsp_rdctl,
  input  logic [DATA_W-1:0]  mc_rsp_data,
  output logic               mc_rsp_stall,
  input  logic               mc_wr_cmp,
  output logic               mem_idle,
  output logic               err
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int FW = TAG_W + DATA_W;
  localparam logic [CW-1:0] C_ONE   = 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(RSP_DEPTH);

  req_ent_t          ent_q [2], ent_d [2];
  req_ent_t          head, new_ent;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     used_q, used_d, infl_q, infl_d, fifo_cnt;
  logic [15:0]       pst_q, pst_d;
  logic              stall_q, stall_d, err_q, err_d, push_q, push_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [FW-1:0]     fifo_rdata;
  logic              req_v, q_pop, q_push, wr_idx, issue_ld, issue_st, credit_ok;
  logic              fifo_rd, fifo_wr, rsp_ok, cmp_ok, pst_sat, misalign;
  logic              unused_rdctl;

  assign unused_rdctl = ^mc_rsp_rdctl[RDCTL_W-1:TAG_W];

`ifdef SPMV_MEM_ADDR_CHECK_EN
  assign misalign = (req_mem_ld | req_mem_st) & (req_mem_addr[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    req_v     = req_mem_ld | req_mem_st;
    head      = ent_q[0];
    q_pop     = (cnt_q != 2'd0) && !mc_req_stall;
    issue_ld  = q_pop & head.ld;
    issue_st  = q_pop & head.st;
    fifo_rd   = (fifo_cnt != '0) && !rsp_mem_stall;
    // A load needs a free credit; a same-cycle PE pop frees one.
    credit_ok = !req_mem_ld || (used_q != C_DEPTH) || fifo_rd;
    q_push    = req_v && ((cnt_q != 2'd2) || q_pop) && credit_ok;
    rsp_ok    = mc_rsp_push && (infl_q != '0);
    fifo_wr   = rsp_ok && ((fifo_cnt != C_DEPTH) || fifo_rd);
    cmp_ok    = mc_wr_cmp && (pst_q != '0);

    new_ent.ld   = req_mem_ld;
    new_ent.st   = req_mem_st & ~req_mem_ld;
    new_ent.addr = req_mem_addr;
    new_ent.d    = req_mem_ld ? ld_rdctl(req_mem_d_or_tag, TAG_W) : req_mem_d_or_tag;

    ent_d = ent_q;
    if (q_pop) begin
      ent_d[0] = ent_q[1];
      ent_d[1] = '0;
    end
    wr_idx = !((cnt_q == 2'd0) || ((cnt_q == 2'd1) && q_pop));
    if (q_push) ent_d[wr_idx] = new_ent;

    cnt_d = cnt_q;
    if (q_push && !q_pop)      cnt_d = cnt_q + 2'd1;
    else if (!q_push && q_pop) cnt_d = cnt_q - 2'd1;

    used_d = used_q;
    if (q_push && req_mem_ld && !fifo_rd)       used_d = used_q + C_ONE;
    else if (!(q_push && req_mem_ld) && fifo_rd) used_d = used_q - C_ONE;

    infl_d = infl_q;
    if (issue_ld && !rsp_ok)      infl_d = infl_q + C_ONE;
    else if (!issue_ld && rsp_ok) infl_d = infl_q - C_ONE;

    pst_sat = 1'b0;
    pst_d   = pst_q;
    if (issue_st && !cmp_ok) begin
      if (pst_q == '1) pst_sat = 1'b1;
      else             pst_d   = pst_q + 16'd1;
    end else if (!issue_st && cmp_ok) begin
      pst_d = pst_q - 16'd1;
    end

    stall_d = ((cnt_d != 2'd0) && mc_req_stall) || (cnt_d == 2'd2) ||
              (used_d > C_DEPTH - 2 * C_ONE);
    err_d   = err_q | (req_v & ~q_push) | (mc_rsp_push & ~rsp_ok) | (mc_wr_cmp & ~cmp_ok) |
              pst_sat | (rsp_ok & ~fifo_wr) | misalign;

    push_d = fifo_rd;
    tag_d  = fifo_rd ? fifo_rdata[FW-1:DATA_W] : tag_q;
    q_d    = fifo_rd ? fifo_rdata[DATA_W-1:0]  : q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= '0;
      used_q   <= '0;
      infl_q   <= '0;
      pst_q    <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      push_q   <= 1'b0;
      tag_q    <= '0;
      q_q      <= '0;
    end else begin
      ent_q    <= ent_d;
      cnt_q    <= cnt_d;
      used_q   <= used_d;
      infl_q   <= infl_d;
      pst_q    <= pst_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      push_q   <= push_d;
      tag_q    <= tag_d;
      q_q      <= q_d;
    end
  end

  spmv_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(FW)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({mc_rsp_rdctl[RDCTL_TAG_LSB +: TAG_W], mc_rsp_data}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .count   (fifo_cnt)
  );

  assign req_mem_stall    = stall_q;
  assign rsp_mem_push     = push_q;
  assign rsp_mem_tag      = tag_q;
  assign rsp_mem_q        = q_q;
  assign mc_req_ld        = (cnt_q != 2'd0) & head.ld;
  assign mc_req_st        = (cnt_q != 2'd0) & head.st;
  assign mc_req_vadr      = head.addr;
  assign mc_req_wrd_rdctl = head.d;
  assign mc_rsp_stall     = 1'b0;
  assign err              = err_q;
  assign mem_idle         = (cnt_q == 2'd0) && (infl_q == '0) && (fifo_cnt == '0) &&
                            (pst_q == '0) && !push_q;

endmodule

// File: tb/tb_spmv_pe_mem_port.sv
// Directed bench for spmv_pe_mem_port with MC/response scoreboards.
module tb_spmv_pe_mem_port;

  localparam int RSP_DEPTH = 16;
  localparam int TAG_W     = 3;
  localparam logic [63:0] TAG_MASK = (64'd1 << TAG_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_mem_ld, req_mem_st, req_mem_stall;
  logic [47:0]       req_mem_addr;
  logic [63:0]       req_mem_d_or_tag;
  logic              rsp_mem_push, rsp_mem_stall;
  logic [TAG_W-1:0]  rsp_mem_tag;
  logic [63:0]       rsp_mem_q;
  logic              mc_req_ld, mc_req_st, mc_req_stall;
  logic [47:0]       mc_req_vadr;
  logic [63:0]       mc_req_wrd_rdctl;
  logic              mc_rsp_push, mc_rsp_stall, mc_wr_cmp;
  logic [31:0]       mc_rsp_rdctl;
  logic [63:0]       mc_rsp_data;
  logic              mem_idle, err;

  always #5 clk = ~clk;

  spmv_pe_mem_port #(.RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
    .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_req_stall(mc_req_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
    .mc_rsp_stall(mc_rsp_stall), .mc_wr_cmp(mc_wr_cmp),
    .mem_idle(mem_idle), .err(err)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [47:0] a;
    logic [63:0] d;
  } mreq_t;

  mreq_t       exp_mc[$];
  logic [66:0] exp_rsp[$];
  logic [31:0] ld_pend[$];
  mreq_t       mon_e;
  logic [66:0] mon_r;

  int   checks = 0, errors = 0, cyc = 0;
  int   mc_seen = 0, mc_ld_seen = 0, rsp_seen = 0, first_rsp = -1, last_rsp = -1;
  logic prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_stall <= req_mem_stall;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((mc_req_ld || mc_req_st) && !mc_req_stall) begin
        mc_seen++;
        chk("mc_exp_avail", exp_mc.size() != 0, 1);
        if (exp_mc.size() != 0) begin
          mon_e = exp_mc.pop_front();
          chk("mc_ld", mc_req_ld, mon_e.ld);
          chk("mc_st", mc_req_st, mon_e.st);
          chk("mc_vadr", mc_req_vadr, mon_e.a);
          chk("mc_wrd", mc_req_wrd_rdctl, mon_e.d);
        end
        if (mc_req_ld) begin
          mc_ld_seen++;
          ld_pend.push_back(mc_req_wrd_rdctl[31:0]);
        end
      end
      if (rsp_mem_push) begin
        rsp_seen++;
        if (first_rsp < 0) first_rsp = cyc;
        last_rsp = cyc;
        chk("rsp_exp_avail", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_tag", rsp_mem_tag, mon_r[64 +: TAG_W]);
          chk("rsp_q", rsp_mem_q, mon_r[63:0]);
        end
      end
    end
  end

  // PE behaviour: issue while stall is low, plus one request in the cycle it rises.
  task automatic pe_req(input logic ld, input logic [47:0] a, input logic [63:0] d,
                        input int max_wait, output logic ok);
    int    n;
    mreq_t e;
    n  = 0;
    ok = 1'b0;
    while (req_mem_stall && prev_stall && n < max_wait) begin
      tick(1);
      n++;
    end
    if (!(req_mem_stall && prev_stall)) begin
      req_mem_ld       = ld;
      req_mem_st       = !ld;
      req_mem_addr     = a;
      req_mem_d_or_tag = d;
      e.ld = ld;
      e.st = !ld;
      e.a  = a;
      e.d  = ld ? (d & TAG_MASK) : d;
      exp_mc.push_back(e);
      ok = 1'b1;
      tick(1);
      req_mem_ld = 1'b0;
      req_mem_st = 1'b0;
    end
  endtask

  task automatic mc_return(input logic [63:0] data);
    logic [31:0] rc;
    chk("ld_pend_avail", ld_pend.size() != 0, 1);
    if (ld_pend.size() != 0) begin
      rc           = ld_pend.pop_front();
      mc_rsp_push  = 1'b1;
      mc_rsp_rdctl = rc;
      mc_rsp_data  = data;
      exp_rsp.push_back({rc[TAG_W-1:0], data});
      tick(1);
      mc_rsp_push = 1'b0;
    end
  endtask

  task automatic wcmp();
    mc_wr_cmp = 1'b1;
    tick(1);
    mc_wr_cmp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_mc.delete();
    exp_rsp.delete();
    ld_pend.delete();
    tick(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok, exp_align;
    logic [31:0] rc;
    int          issued, base, rbase;

    rst = 1'b1;
    req_mem_ld = 0; req_mem_st = 0; req_mem_addr = '0; req_mem_d_or_tag = '0;
    rsp_mem_stall = 0; mc_req_stall = 0; mc_rsp_push = 0; mc_rsp_rdctl = '0;
    mc_rsp_data = '0; mc_wr_cmp = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_req_stall", req_mem_stall, 0);
    chk("rst_mem_idle", mem_idle, 1);
    chk("rst_err", err, 0);
    chk("rst_rsp_push", rsp_mem_push, 0);
    chk("rst_rsp_q", rsp_mem_q, 0);
    chk("rst_mc_ld", mc_req_ld, 0);
    chk("rst_mc_st", mc_req_st, 0);
    chk("rst_mc_rsp_stall", mc_rsp_stall, 0);

    // Single load, response latency
    pe_req(1'b1, 48'h40, 64'd5, 8, ok);
    chk("t1_issue", ok, 1);
    tick(3);
    chk("t1_ld_pend", ld_pend.size(), 1);
    if (ld_pend.size() != 0) begin
      rc = ld_pend.pop_front();
      mc_rsp_push = 1'b1; mc_rsp_rdctl = rc; mc_rsp_data = 64'hDEAD;
      exp_rsp.push_back({rc[TAG_W-1:0], 64'hDEAD});
      tick(1);
      mc_rsp_push = 1'b0;
      chk("t1_push_early", rsp_mem_push, 0);
      tick(1);
      chk("t1_push", rsp_mem_push, 1);
      chk("t1_tag", rsp_mem_tag, 5);
      chk("t1_q", rsp_mem_q, 64'hDEAD);
    end
    tick(2);
    chk("t1_idle", mem_idle, 1);

    // Credit exhaustion: MC never answers
    base = mc_ld_seen;
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      pe_req(1'b1, 48'h1000 + 48'(i * 8), 64'(i), 4, ok);
      if (ok) issued++;
    end
    tick(4);
    chk("t2_issued", issued, RSP_DEPTH);
    chk("t2_mc_loads", mc_ld_seen - base, RSP_DEPTH);
    chk("t2_stall", req_mem_stall, 1);
    chk("t2_idle", mem_idle, 0);
    chk("t2_err", err, 0);

    // Fill FIFO under PE backpressure, then drain
    rsp_mem_stall = 1'b1;
    rbase = rsp_seen;
    for (int i = 0; i < RSP_DEPTH; i++) mc_return(64'h1000 + 64'(i));
    tick(50);
    chk("t3_held", rsp_seen - rbase, 0);
    chk("t3_stall_held", req_mem_stall, 1);
    first_rsp = -1;
    rsp_mem_stall = 1'b0;
    tick(20);
    chk("t3_pops", rsp_seen - rbase, RSP_DEPTH);
    chk("t3_burst", last_rsp - first_rsp, RSP_DEPTH - 1);
    chk("t3_stall_free", req_mem_stall, 0);
    chk("t3_idle", mem_idle, 1);

    // MC stall during mixed traffic
    base = mc_seen;
    mc_req_stall = 1'b1;
    fork
      begin
        tick(10);
        mc_req_stall = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          pe_req((i % 2) == 0, 48'h2000 + 48'(i * 8),
                 ((i % 2) == 0) ? 64'(i) : 64'hA5A5_0000 + 64'(i), 40, ok);
          chk("t4_issue", ok, 1);
        end
      end
    join
    tick(4);
    chk("t4_count", mc_seen - base, 6);
    chk("t4_exp_left", exp_mc.size(), 0);
    for (int i = 0; i < 3; i++) mc_return(64'hB000 + 64'(i));
    for (int i = 0; i < 3; i++) wcmp();
    tick(4);
    chk("t4_idle", mem_idle, 1);
    chk("t4_err", err, 0);

    // Stores with one completion coincident with a store issue
    base = mc_seen;
    pe_req(1'b0, 48'h3000, 64'h1111, 8, ok);
    tick(2);
    pe_req(1'b0, 48'h3008, 64'h2222, 8, ok);
    mc_wr_cmp = 1'b1;
    tick(1);
    mc_wr_cmp = 1'b0;
    pe_req(1'b0, 48'h3010, 64'h3333, 8, ok);
    pe_req(1'b0, 48'h3018, 64'h4444, 8, ok);
    tick(3);
    chk("t5_count", mc_seen - base, 4);
    wcmp();
    wcmp();
    chk("t5_idle_busy", mem_idle, 0);
    wcmp();
    chk("t5_idle", mem_idle, 1);
    chk("t5_err", err, 0);

    // Reset mid-flight, then a stray MC response
    pe_req(1'b1, 48'h4000, 64'd1, 8, ok);
    pe_req(1'b1, 48'h4008, 64'd2, 8, ok);
    tick(3);
    chk("t6_busy", mem_idle, 0);
    do_reset();
    chk("t6_rst_stall", req_mem_stall, 0);
    chk("t6_rst_idle", mem_idle, 1);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_mc_ld", mc_req_ld, 0);
    rbase = rsp_seen;
    mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'd1; mc_rsp_data = 64'hBAD;
    tick(1);
    mc_rsp_push = 1'b0;
    tick(3);
    chk("t6_stray_err", err, 1);
    chk("t6_discard", rsp_seen - rbase, 0);
    chk("t6_idle", mem_idle, 1);

    do_reset();
    wcmp();
    chk("t7_stray_cmp_err", err, 1);

    // Misaligned address
    do_reset();
`ifdef SPMV_MEM_ADDR_CHECK_EN
    exp_align = 1'b1;
`else
    exp_align = 1'b0;
`endif
    base = mc_ld_seen;
    pe_req(1'b1, 48'h43, 64'd6, 8, ok);
    tick(3);
    chk("t8_align_err", err, exp_align);
    chk("t8_forwarded", mc_ld_seen - base, 1);
    mc_return(64'hCAFE);
    tick(4);
    chk("t8_idle", mem_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
